// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU:
// opcodes, sequencer states and address width.
package cpu_pkg;

  localparam int PHASES = 8;
  localparam int AW     = 5;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Run phases encode their own index in bits [2:0]
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    WAIT       = 4'd8,
    LOAD       = 4'd9,
    HALTED     = 4'd10
  } state_t;

  function automatic logic is_aluop(
    input logic [2:0] op
  );
    return (op == OP_ADD) || (op == OP_AND) ||
           (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath/memory strobe bundle.
// master = sequencer side, slave = datapath side.
interface cpu_controller_if;
  import cpu_pkg::*;

  logic                      Load;
  logic [2:0]                opcode;
  logic                      zero;
  logic                      sel;
  logic                      rd;
  logic                      ld_ir;
  logic                      inc_pc;
  logic                      ld_pc;
  logic                      clr_pc;
  logic                      ld_ac;
  logic                      data_e;
  logic                      wr;
  logic                      mem_ld;
  logic [AW-1:0]             load_addr;
  logic                      halt;
  logic [$clog2(PHASES)-1:0] phase;

  modport master (
    input  Load, opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc,
    output clr_pc, ld_ac, data_e, wr,
    output mem_ld, load_addr, halt, phase
  );

  modport slave (
    output Load, opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc,
    input  clr_pc, ld_ac, data_e, wr,
    input  mem_ld, load_addr, halt, phase
  );

endinterface

// File: rtl/cpu_loader.sv
// Program-load address counter; writes data_in at
// consecutive addresses, wrapping silently.
module cpu_loader
  import cpu_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_clr,
  output logic          o_mem_ld,
  output logic [AW-1:0] o_addr
);

  logic [AW-1:0] r_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
    end else if (i_clr) begin
      r_addr <= '0;
    end else if (i_en) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_mem_ld = i_en;
  assign o_addr   = r_addr;

endmodule

// File: rtl/cpu_controller.sv
// 8-phase fetch/execute sequencer with program-load
// mode; strobes decoded from state, opcode and zero.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  cpu_controller_if.master bus
);

  state_t r_state;

  logic w_alu;
  logic w_skz;
  logic w_sto;
  logic w_jmp;
  logic w_hlt;
  logic w_ld_en;
  logic w_ld_clr;

  logic       w_sel, w_rd, w_ld_ir, w_inc_pc;
  logic       w_ld_pc, w_clr_pc, w_ld_ac;
  logic       w_data_e, w_wr, w_halt;
  logic [2:0] w_phase;

  assign w_alu = is_aluop(bus.opcode);
  assign w_skz = (bus.opcode == OP_SKZ);
  assign w_sto = (bus.opcode == OP_STO);
  assign w_jmp = (bus.opcode == OP_JMP);
  assign w_hlt = (bus.opcode == OP_HLT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= WAIT;
    end else begin
      unique case (r_state)
        WAIT:       if (bus.Load) r_state <= LOAD;
        LOAD:       if (!bus.Load) r_state <= INST_ADDR;
        HALTED:     if (bus.Load) r_state <= LOAD;
        INST_ADDR:  r_state <= INST_FETCH;
        INST_FETCH: r_state <= INST_LOAD;
        INST_LOAD:  r_state <= IDLE;
        IDLE:       r_state <= OP_ADDR;
        OP_ADDR:    r_state <= w_hlt ? HALTED : OP_FETCH;
        OP_FETCH:   r_state <= ALU_OP;
        ALU_OP:     r_state <= STORE;
        STORE:      r_state <= INST_ADDR;
        default:    r_state <= WAIT;
      endcase
    end
  end

  // Load is only honoured while waiting or loading
  assign w_ld_en  = bus.Load &&
                    ((r_state == WAIT) || (r_state == LOAD));
  assign w_ld_clr = ((r_state == LOAD) && !bus.Load) ||
                    ((r_state == HALTED) && bus.Load);

  always_comb begin
    w_sel    = 1'b0;
    w_rd     = 1'b0;
    w_ld_ir  = 1'b0;
    w_inc_pc = 1'b0;
    w_ld_pc  = 1'b0;
    w_clr_pc = 1'b0;
    w_ld_ac  = 1'b0;
    w_data_e = 1'b0;
    w_wr     = 1'b0;
    w_halt   = 1'b0;
    w_phase  = '0;
    if (!r_state[3]) w_phase = r_state[2:0];
    unique case (r_state)
      LOAD:       w_clr_pc = !bus.Load;
      HALTED:     w_halt = 1'b1;
      INST_ADDR:  w_sel = 1'b1;
      INST_FETCH: begin
        w_sel = 1'b1;
        w_rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        w_sel   = 1'b1;
        w_rd    = 1'b1;
        w_ld_ir = 1'b1;
      end
      OP_ADDR: begin
        w_inc_pc = 1'b1;
        w_halt   = w_hlt;
      end
      OP_FETCH:   w_rd = w_alu;
      ALU_OP: begin
        w_rd     = w_alu;
        w_inc_pc = w_skz && bus.zero;
        w_ld_pc  = w_jmp;
        w_data_e = w_sto;
      end
      STORE: begin
        w_rd     = w_alu;
        w_ld_ac  = w_alu;
        w_ld_pc  = w_jmp;
        w_wr     = w_sto;
        w_data_e = w_sto;
      end
      default: ;
    endcase
  end

  assign bus.sel    = w_sel;
  assign bus.rd     = w_rd;
  assign bus.ld_ir  = w_ld_ir;
  assign bus.inc_pc = w_inc_pc;
  assign bus.ld_pc  = w_ld_pc;
  assign bus.clr_pc = w_clr_pc;
  assign bus.ld_ac  = w_ld_ac;
  assign bus.data_e = w_data_e;
  assign bus.wr     = w_wr;
  assign bus.halt   = w_halt;
  assign bus.phase  = w_phase;

  cpu_loader u_loader (
    .clock    (clock),
    .reset    (reset),
    .i_en     (w_ld_en),
    .i_clr    (w_ld_clr),
    .o_mem_ld (bus.mem_ld),
    .o_addr   (bus.load_addr)
  );

endmodule
